z16_fetch_unit: RTL and testbench

//   Z16 instruction fetch stage, directly upstream of Z16InstrMemory.

---
 rtl/z16_fetch_unit_if.sv | 23 ++
 rtl/z16_fetch_unit.sv | 70 +++++++
 tb/tb_z16_fetch_unit.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/z16_fetch_unit_if.sv
// Fetch-stage bus: instruction memory address/data, decode handshake and
// execute redirect. master = fetch unit side, slave = environment side.
interface z16_fetch_unit_if;
   logic [15:0] o_imem_addr;
   logic [15:0] i_imem_instr;
   logic        i_jump_en;
   logic [15:0] i_jump_addr;
   logic        o_valid;
   logic        i_ready;
   logic [15:0] o_instr;
   logic [15:0] o_pc;
   logic        o_halted;

   modport master (
      output o_imem_addr, o_valid, o_instr, o_pc, o_halted,
      input  i_imem_instr, i_jump_en, i_jump_addr, i_ready
   );

   modport slave (
      input  o_imem_addr, o_valid, o_instr, o_pc, o_halted,
      output i_imem_instr, i_jump_en, i_jump_addr, i_ready
   );
endinterface

// File: rtl/z16_fetch_unit.sv
// Z16 fetch stage: owns the PC, addresses instruction memory and registers the
// returned word into the fetch/decode latch. Optional halt-on-zero: Z16_FETCH_HALT_EN.
module z16_fetch_unit #(
   parameter logic [15:0] RESET_PC = 16'h0000
) (
   input logic              i_clk,
   input logic              i_rst_n,
   z16_fetch_unit_if.master bus
);
   localparam logic [15:0] START_PC = RESET_PC & 16'hFFFE;

   logic [15:0] pc;
   logic        valid_q;
   logic [15:0] instr_q;
   logic [15:0] pc_q;
   logic        advance;
   logic        running;
   logic        halt_word;

`ifdef Z16_FETCH_HALT_EN
   typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;
   state_t state;

   assign running      = (state == RUN);
   assign halt_word    = (bus.i_imem_instr == 16'h0000);
   assign bus.o_halted = (state == HALT);
`else
   assign running      = 1'b1;
   assign halt_word    = 1'b0;
   assign bus.o_halted = 1'b0;
`endif

   // Latch is free when empty or being drained by decode this cycle.
   assign advance = !valid_q || bus.i_ready;

   assign bus.o_imem_addr = pc;
   assign bus.o_valid     = valid_q;
   assign bus.o_instr     = instr_q;
   assign bus.o_pc        = pc_q;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values; reset is synchronous, tested inside the clocked block.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         pc      <= START_PC;
         valid_q <= 1'b0;
         instr_q <= 16'h0000;
         pc_q    <= 16'h0000;
`ifdef Z16_FETCH_HALT_EN
         state   <= RUN;
`endif
      end else if (running) begin
         if (bus.i_jump_en) begin
            // Redirect flushes the latch whether or not decode took the word.
            pc      <= bus.i_jump_addr & 16'hFFFE;
            valid_q <= 1'b0;
         end else if (advance && halt_word) begin
            valid_q <= 1'b0;
`ifdef Z16_FETCH_HALT_EN
            state   <= HALT;
`endif
         end else if (advance) begin
            instr_q <= bus.i_imem_instr;
            pc_q    <= pc;
            valid_q <= 1'b1;
            pc      <= pc + 16'd2;
         end
      end
   end
endmodule

// File: tb/tb_z16_fetch_unit.sv
// Self-checking bench for z16_fetch_unit: directed scenarios plus a randomized
// run against a transaction-level model of the delivered instruction stream.
module tb_z16_fetch_unit;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   z16_fetch_unit_if bus ();
   z16_fetch_unit_if wbus ();

   logic [15:0] rom [0:32767];
   assign bus.i_imem_instr  = rom[bus.o_imem_addr[15:1]];
   assign wbus.i_imem_instr = rom[wbus.o_imem_addr[15:1]];

   z16_fetch_unit #(.RESET_PC(16'h0000)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .bus(bus.master)
   );
   z16_fetch_unit #(.RESET_PC(16'hFFFE)) dut_wrap (
      .i_clk(clk), .i_rst_n(rst_n), .bus(wbus.master)
   );

   int total = 0;
   int bad   = 0;

   task automatic apply_reset();
      @(negedge clk);
      rst_n            = 1'b0;
      bus.i_ready      = 1'b0;
      bus.i_jump_en    = 1'b0;
      bus.i_jump_addr  = 16'h0000;
      wbus.i_ready     = 1'b1;
      wbus.i_jump_en   = 1'b0;
      wbus.i_jump_addr = 16'h0000;
      @(negedge clk);
   endtask

   task automatic test_reset();
      apply_reset();
      total++; if (bus.o_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", bus.o_valid); end
      total++; if (bus.o_pc !== 16'h0000) begin bad++; $display("FAIL reset_pc: got %h want 0000", bus.o_pc); end
      total++; if (bus.o_instr !== 16'h0000) begin bad++; $display("FAIL reset_instr: got %h want 0000", bus.o_instr); end
      total++; if (bus.o_halted !== 1'b0) begin bad++; $display("FAIL reset_halted: got %b want 0", bus.o_halted); end
      total++; if (bus.o_imem_addr !== 16'h0000) begin bad++; $display("FAIL reset_addr: got %h want 0000", bus.o_imem_addr); end
      total++; if (wbus.o_imem_addr !== 16'hFFFE) begin bad++; $display("FAIL reset_addr_wrap: got %h want fffe", wbus.o_imem_addr); end
   endtask

   task automatic test_stream();
      logic [15:0] want [3];
      want[0] = 16'h0040; want[1] = 16'h0050; want[2] = 16'h0080;
      apply_reset();
      rst_n = 1'b1;
      bus.i_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         total++; if (bus.o_valid !== 1'b1) begin bad++; $display("FAIL stream_valid[%0d]: got %b want 1", k, bus.o_valid); end
         total++; if (bus.o_pc !== 16'(2 * k)) begin bad++; $display("FAIL stream_pc[%0d]: got %h want %h", k, bus.o_pc, 16'(2 * k)); end
         total++; if (bus.o_instr !== want[k]) begin bad++; $display("FAIL stream_instr[%0d]: got %h want %h", k, bus.o_instr, want[k]); end
      end
   endtask

   task automatic test_stall();
      apply_reset();
      rst_n = 1'b1;
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         total++; if (bus.o_pc !== 16'h0000 || bus.o_instr !== 16'h0040 || bus.o_valid !== 1'b1)
            begin bad++; $display("FAIL stall_hold[%0d]: got pc=%h instr=%h v=%b want pc=0000 instr=0040 v=1", k, bus.o_pc, bus.o_instr, bus.o_valid); end
         total++; if (bus.o_imem_addr !== 16'h0002) begin bad++; $display("FAIL stall_addr[%0d]: got %h want 0002", k, bus.o_imem_addr); end
      end
      bus.i_ready = 1'b1;
      @(negedge clk);
      total++; if (bus.o_pc !== 16'h0002 || bus.o_instr !== 16'h0050)
         begin bad++; $display("FAIL stall_release: got pc=%h instr=%h want pc=0002 instr=0050", bus.o_pc, bus.o_instr); end
   endtask

   task automatic test_jump_stall();
      apply_reset();
      rst_n = 1'b1;
      @(negedge clk);
      bus.i_jump_en   = 1'b1;
      bus.i_jump_addr = 16'h0013;
      @(negedge clk);
      bus.i_jump_en = 1'b0;
      total++; if (bus.o_valid !== 1'b0) begin bad++; $display("FAIL jump_flush: got %b want 0", bus.o_valid); end
      total++; if (bus.o_imem_addr !== 16'h0012) begin bad++; $display("FAIL jump_addr: got %h want 0012", bus.o_imem_addr); end
      total++; if (bus.o_pc !== 16'h0000) begin bad++; $display("FAIL jump_pc_kept: got %h want 0000", bus.o_pc); end
      bus.i_ready = 1'b1;
      @(negedge clk);
      total++; if (bus.o_valid !== 1'b1 || bus.o_pc !== 16'h0012 || bus.o_instr !== rom[9])
         begin bad++; $display("FAIL jump_target: got v=%b pc=%h instr=%h want v=1 pc=0012 instr=%h", bus.o_valid, bus.o_pc, bus.o_instr, rom[9]); end
   endtask

   task automatic test_wrap();
      apply_reset();
      rst_n = 1'b1;
      @(negedge clk);
      total++; if (wbus.o_valid !== 1'b1 || wbus.o_pc !== 16'hFFFE)
         begin bad++; $display("FAIL wrap_first: got v=%b pc=%h want v=1 pc=fffe", wbus.o_valid, wbus.o_pc); end
      @(negedge clk);
      total++; if (wbus.o_pc !== 16'h0000 || wbus.o_instr !== rom[0])
         begin bad++; $display("FAIL wrap_second: got pc=%h instr=%h want pc=0000 instr=%h", wbus.o_pc, wbus.o_instr, rom[0]); end
   endtask

   task automatic test_mid_reset();
      apply_reset();
      rst_n = 1'b1;
      bus.i_ready = 1'b1;
      repeat (4) @(negedge clk);
      bus.i_ready = 1'b0;
      rst_n = 1'b0;
      @(negedge clk);
      total++; if (bus.o_valid !== 1'b0 || bus.o_pc !== 16'h0000 || bus.o_instr !== 16'h0000)
         begin bad++; $display("FAIL midreset_clear: got v=%b pc=%h instr=%h want 0/0000/0000", bus.o_valid, bus.o_pc, bus.o_instr); end
      rst_n = 1'b1;
      bus.i_ready = 1'b1;
      @(negedge clk);
      total++; if (bus.o_valid !== 1'b1 || bus.o_pc !== 16'h0000)
         begin bad++; $display("FAIL midreset_restart: got v=%b pc=%h want v=1 pc=0000", bus.o_valid, bus.o_pc); end
   endtask

   task automatic test_halt();
      logic [15:0] saved;
      saved   = rom[10];
      rom[10] = 16'h0000;
      apply_reset();
      rst_n = 1'b1;
      bus.i_ready = 1'b1;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         total++; if (bus.o_valid !== 1'b1 || bus.o_pc !== 16'(2 * k))
            begin bad++; $display("FAIL halt_run[%0d]: got v=%b pc=%h want v=1 pc=%h", k, bus.o_valid, bus.o_pc, 16'(2 * k)); end
      end
      @(negedge clk);
`ifdef Z16_FETCH_HALT_EN
      total++; if (bus.o_valid !== 1'b0 || bus.o_halted !== 1'b1 || bus.o_imem_addr !== 16'h0014)
         begin bad++; $display("FAIL halt_enter: got v=%b h=%b addr=%h want 0/1/0014", bus.o_valid, bus.o_halted, bus.o_imem_addr); end
      bus.i_jump_en   = 1'b1;
      bus.i_jump_addr = 16'h0040;
      @(negedge clk);
      bus.i_jump_en = 1'b0;
      repeat (2) @(negedge clk);
      total++; if (bus.o_valid !== 1'b0 || bus.o_halted !== 1'b1 || bus.o_imem_addr !== 16'h0014)
         begin bad++; $display("FAIL halt_jump_ignored: got v=%b h=%b addr=%h want 0/1/0014", bus.o_valid, bus.o_halted, bus.o_imem_addr); end
      // A jump on the edge that would capture the halt word wins.
      apply_reset();
      rst_n = 1'b1;
      bus.i_ready = 1'b1;
      repeat (10) @(negedge clk);
      bus.i_jump_en   = 1'b1;
      bus.i_jump_addr = 16'h0030;
      @(negedge clk);
      bus.i_jump_en = 1'b0;
      total++; if (bus.o_halted !== 1'b0 || bus.o_valid !== 1'b0 || bus.o_imem_addr !== 16'h0030)
         begin bad++; $display("FAIL halt_jump_wins: got h=%b v=%b addr=%h want 0/0/0030", bus.o_halted, bus.o_valid, bus.o_imem_addr); end
      @(negedge clk);
      total++; if (bus.o_valid !== 1'b1 || bus.o_pc !== 16'h0030)
         begin bad++; $display("FAIL halt_jump_target: got v=%b pc=%h want v=1 pc=0030", bus.o_valid, bus.o_pc); end
`else
      total++; if (bus.o_valid !== 1'b1 || bus.o_pc !== 16'h0014 || bus.o_instr !== 16'h0000 || bus.o_halted !== 1'b0)
         begin bad++; $display("FAIL zero_forward: got v=%b pc=%h instr=%h h=%b want 1/0014/0000/0", bus.o_valid, bus.o_pc, bus.o_instr, bus.o_halted); end
`endif
      rom[10] = saved;
   endtask

   // Model: the delivered stream is rom[next], rom[next+2], ... restarting at
   // each jump target; a jump or reset leaves the latch empty for one cycle.
   task automatic test_random();
      logic [15:0] exp_next;
      logic [15:0] exp_addr;
      logic [15:0] target;
      logic        exp_valid;
      logic        prev_flush;
      logic        prev_valid;
      logic        prev_ready;
      logic        rdy;
      logic        jmp;
      apply_reset();
      rst_n      = 1'b1;
      exp_next   = 16'h0000;
      prev_flush = 1'b1;
      prev_valid = 1'b0;
      prev_ready = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         if (prev_flush)                     exp_valid = 1'b0;
         else if (!prev_valid || prev_ready) exp_valid = 1'b1;
         else                                exp_valid = 1'b1;
         total++; if (bus.o_valid !== exp_valid) begin bad++; $display("FAIL rand_valid@%0d: got %b want %b", c, bus.o_valid, exp_valid); end
         if (exp_valid) begin
            total++; if (bus.o_pc !== exp_next || bus.o_instr !== rom[exp_next[15:1]])
               begin bad++; $display("FAIL rand_word@%0d: got pc=%h instr=%h want pc=%h instr=%h", c, bus.o_pc, bus.o_instr, exp_next, rom[exp_next[15:1]]); end
         end
         exp_addr = exp_valid ? 16'(exp_next + 16'd2) : exp_next;
         total++; if (bus.o_imem_addr !== exp_addr) begin bad++; $display("FAIL rand_addr@%0d: got %h want %h", c, bus.o_imem_addr, exp_addr); end
         total++; if (bus.o_halted !== 1'b0) begin bad++; $display("FAIL rand_halted@%0d: got %b want 0", c, bus.o_halted); end

         rdy    = ($urandom_range(0, 9) < 7);
         jmp    = ($urandom_range(0, 9) == 0);
         target = ($urandom_range(0, 3) == 0) ? 16'(16'hFFF8 + $urandom_range(0, 7)) : 16'($urandom);
         bus.i_ready     = rdy;
         bus.i_jump_en   = jmp;
         bus.i_jump_addr = target;
         if (exp_valid && rdy) exp_next = 16'(exp_next + 16'd2);
         if (jmp)              exp_next = target & 16'hFFFE;
         prev_flush = jmp;
         prev_valid = exp_valid;
         prev_ready = rdy;
         @(negedge clk);
      end
      bus.i_jump_en = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 32768; i++) rom[i] = 16'($urandom_range(1, 65535));
      rom[0] = 16'h0040;
      rom[1] = 16'h0050;
      rom[2] = 16'h0080;
      bus.i_ready      = 1'b0;
      bus.i_jump_en    = 1'b0;
      bus.i_jump_addr  = 16'h0000;
      wbus.i_ready     = 1'b1;
      wbus.i_jump_en   = 1'b0;
      wbus.i_jump_addr = 16'h0000;

      test_reset();
      test_stream();
      test_stall();
      test_jump_stall();
      test_wrap();
      test_mid_reset();
      test_halt();
      test_random();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
